// File: rtl/zaxxon_sound_pkg.sv
// Shared constants, waveform table and saturation helper for the Zaxxon discrete-sound voices.
package zaxxon_sound_pkg;

    localparam int WAVE_LEN = 6;
    localparam int WAVE_W   = 16;
    localparam int IDX_W    = 3;

    function automatic logic signed [WAVE_W-1:0] wave_val(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return 16'sd13107;
            3'd1:    return 16'sd11468;
            3'd2:    return 16'sd9830;
            3'd3:    return -16'sd13107;
            3'd4:    return -16'sd11468;
            3'd5:    return -16'sd9830;
            default: return '0;
        endcase
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/zaxxon_sound_voice.sv
// One sound voice: trigger edge detect, period divider, wave step index, envelope and scaled sample.
module zaxxon_sound_voice
    import zaxxon_sound_pkg::*;
#(
    parameter int DIV_W = 17,
    parameter int ENV_W = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     i_trig,
    input  logic                     i_loop_mode,
    input  logic                     i_decay_tick,
    input  logic [DIV_W-1:0]         i_period,
    output logic                     o_active,
    output logic signed [WAVE_W-1:0] o_sample
);

    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    logic                     r_trig_q;
    logic [DIV_W-1:0]         r_cnt_p0;
    logic [IDX_W-1:0]         r_idx_p0;
    logic [ENV_W-1:0]         r_env_p0;
    logic                     r_active_p0;
    logic signed [WAVE_W-1:0] r_sample_p1;

    logic                     w_start;
    logic                     w_muted;
    logic                     w_step_tick;
    logic [DIV_W-1:0]         w_last;
    logic [ENV_W-1:0]         w_env_nxt;
    logic signed [ENV_W:0]    w_env_s;
    logic signed [WAVE_W+ENV_W:0] w_prod;

    assign w_start     = i_trig & ~r_trig_q;
    assign w_muted     = (i_period == '0);
    assign w_last      = i_period - DIV_W'(1);
    assign w_step_tick = !w_muted && (r_cnt_p0 == w_last);

    // A live trigger in loop mode pins the envelope; otherwise it decays toward zero.
    always_comb begin
        w_env_nxt = r_env_p0;
        if (w_start || (i_loop_mode && i_trig))
            w_env_nxt = ENV_MAX;
        else if (i_decay_tick && (r_env_p0 != '0))
            w_env_nxt = r_env_p0 - ENV_W'(1);
    end

    // Stage p0: divider, step index and envelope
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_trig_q    <= 1'b0;
            r_cnt_p0    <= '0;
            r_idx_p0    <= '0;
            r_env_p0    <= '0;
            r_active_p0 <= 1'b0;
        end else begin
            r_trig_q    <= i_trig;
            r_env_p0    <= w_env_nxt;
            r_active_p0 <= (w_env_nxt != '0);
            // Counting at or past the last step also covers a period shortened under the counter.
            if (w_start || w_muted || (r_cnt_p0 >= w_last))
                r_cnt_p0 <= '0;
            else
                r_cnt_p0 <= r_cnt_p0 + DIV_W'(1);
            if (w_start)
                r_idx_p0 <= '0;
            else if (w_step_tick)
                r_idx_p0 <= (r_idx_p0 == IDX_W'(WAVE_LEN - 1)) ? '0 : r_idx_p0 + IDX_W'(1);
        end
    end

    assign w_env_s = {1'b0, r_env_p0};
    assign w_prod  = wave_val(r_idx_p0) * w_env_s;

    // Stage p1: envelope-scaled sample
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_sample_p1 <= '0;
        else if (w_muted)
            r_sample_p1 <= '0;
        else
            r_sample_p1 <= WAVE_W'(w_prod >>> ENV_W);
    end

    assign o_active = r_active_p0;
    assign o_sample = r_sample_p1;

endmodule

// File: rtl/zaxxon_sound_voices.sv
// Zaxxon discrete-sound generator: NUM_CH triggered voices, shared decay prescaler, saturated mix.
module zaxxon_sound_voices
    import zaxxon_sound_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 17,
    parameter int ENV_W     = 8,
    parameter int DECAY_DIV = 48000,
    parameter int OUT_W     = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         i_trig,
    input  logic [NUM_CH-1:0]         i_loop_mode,
    input  logic [NUM_CH*DIV_W-1:0]   i_period,
    output logic [NUM_CH-1:0]         o_active,
    output logic signed [OUT_W-1:0]   o_short_audio
);

    localparam int PRE_W = $clog2(DECAY_DIV + 1);
    localparam int SUM_W = OUT_W + $clog2(NUM_CH);

    logic [PRE_W-1:0]          r_pre_p0;
    logic                      w_decay_tick;
    logic signed [WAVE_W-1:0]  w_sample [NUM_CH];
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [63:0]        w_sum_wide;
    logic signed [OUT_W-1:0]   r_audio_p2;

    assign w_decay_tick = (r_pre_p0 == PRE_W'(DECAY_DIV - 1));

    // Free-running envelope prescaler, shared by every voice
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_pre_p0 <= '0;
        else if (w_decay_tick)
            r_pre_p0 <= '0;
        else
            r_pre_p0 <= r_pre_p0 + PRE_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        zaxxon_sound_voice #(
            .DIV_W (DIV_W),
            .ENV_W (ENV_W)
        ) u_voice (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .i_trig       (i_trig[g]),
            .i_loop_mode  (i_loop_mode[g]),
            .i_decay_tick (w_decay_tick),
            .i_period     (i_period[g*DIV_W +: DIV_W]),
            .o_active     (o_active[g]),
            .o_sample     (w_sample[g])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_sum = w_sum + SUM_W'(w_sample[i]);
    end

    assign w_sum_wide = 64'(w_sum);

    // Stage p2: saturated mix
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_audio_p2 <= '0;
        else
            r_audio_p2 <= OUT_W'(sat_s(w_sum_wide, OUT_W));
    end

    assign o_short_audio = r_audio_p2;

endmodule

// File: tb/tb_zaxxon_sound_voices.sv
// Directed bench for zaxxon_sound_voices with a fast decay prescaler (DECAY_DIV = 4).
module tb_zaxxon_sound_voices;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 17;
    localparam int ENV_W     = 8;
    localparam int DECAY_DIV = 4;
    localparam int OUT_W     = 16;

    logic                      clk_sys = 1'b0;
    logic                      reset   = 1'b1;
    logic [NUM_CH-1:0]         trig    = '0;
    logic [NUM_CH-1:0]         loop_mode = '0;
    logic [NUM_CH*DIV_W-1:0]   period  = '0;
    logic [NUM_CH-1:0]         active;
    logic signed [OUT_W-1:0]   short_audio;

    int n_vec = 0;
    int n_err = 0;

    zaxxon_sound_voices #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .ENV_W     (ENV_W),
        .DECAY_DIV (DECAY_DIV),
        .OUT_W     (OUT_W)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .i_trig        (trig),
        .i_loop_mode   (loop_mode),
        .i_period      (period),
        .o_active      (active),
        .o_short_audio (short_audio)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        reset     = 1'b1;
        trig      = '0;
        loop_mode = '0;
        period    = '0;
        step(2);
    endtask

    initial begin
        // Reset held with all triggers high: everything silent
        trig = 4'hF;
        step(5);
        check("rst_audio", int'(short_audio), 0);
        check("rst_active", int'(active), 0);
        reset = 1'b0;
        step(2);
        check("rel_active", int'(active), 15);
        check("rel_audio_muted", int'(short_audio), 0);

        // Single looped voice, period 10: walk the scaled table
        hold_reset();
        period[0*DIV_W +: DIV_W] = 17'd10;
        loop_mode[0] = 1'b1;
        trig[0]      = 1'b1;
        reset        = 1'b0;
        step(3);
        check("v0_first", int'(short_audio), 13055);
        step(9);
        check("v0_step0_end", int'(short_audio), 13055);
        step(1);
        check("v0_step1", int'(short_audio), 11423);
        step(10);
        check("v0_step2", int'(short_audio), 9791);
        step(10);
        check("v0_step3", int'(short_audio), -13056);
        step(10);
        check("v0_step4", int'(short_audio), -11424);
        step(10);
        check("v0_step5", int'(short_audio), -9792);
        step(10);
        check("v0_wrap", int'(short_audio), 13055);

        // One-shot decay from a single-cycle trigger pulse
        hold_reset();
        period[0*DIV_W +: DIV_W] = 17'd10;
        trig[0] = 1'b1;
        reset   = 1'b0;
        step(1);
        trig[0] = 1'b0;
        step(9);
        check("decay_env253", int'(short_audio), 12953);
        step(1009);
        check("decay_last_active", int'(active), 1);
        step(1);
        check("decay_inactive", int'(active), 0);
        step(2);
        check("decay_silent", int'(short_audio), 0);

        // Loop mode holds the envelope while the trigger stays high
        hold_reset();
        period[1*DIV_W +: DIV_W] = 17'd10;
        loop_mode[1] = 1'b1;
        trig[1]      = 1'b1;
        reset        = 1'b0;
        step(1000);
        check("loop_held_audio", int'(short_audio), -13056);
        check("loop_held_active", int'(active), 2);
        trig[1] = 1'b0;
        step(1019);
        check("loop_decay_last", int'(active), 2);
        step(1);
        check("loop_decay_done", int'(active), 0);

        // Four voices in phase saturate both rails; muting two brings the sum back in range
        hold_reset();
        for (int i = 0; i < NUM_CH; i++)
            period[i*DIV_W +: DIV_W] = 17'd7;
        loop_mode = 4'hF;
        trig      = 4'hF;
        reset     = 1'b0;
        step(3);
        check("sat_pos", int'(short_audio), 32767);
        step(21);
        check("sat_neg", int'(short_audio), -32768);
        period[2*DIV_W +: DIV_W] = '0;
        period[3*DIV_W +: DIV_W] = '0;
        step(2);
        check("two_voice_sum", int'(short_audio), -26112);
        check("muted_still_active", int'(active), 15);

        // Retrigger mid-decay restarts envelope and step index; period 0 mutes
        hold_reset();
        period[0*DIV_W +: DIV_W] = 17'd10;
        trig[0] = 1'b1;
        reset   = 1'b0;
        step(1);
        trig[0] = 1'b0;
        step(39);
        trig[0] = 1'b1;
        step(2);
        check("pre_retrig", int'(short_audio), -12544);
        step(1);
        check("retrig", int'(short_audio), 13055);
        period[0*DIV_W +: DIV_W] = '0;
        step(2);
        check("mute_audio", int'(short_audio), 0);
        check("mute_active", int'(active), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
